// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall, flush, sticky halt and a loaded-instruction counter.
// Optional forwarding outputs are built only when EXMEM_FWD_EN is defined.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [15:0] ex_instr,
  input  logic [15:0] ex_alu_result,
  input  logic        ex_alu_zero,
  input  logic        ex_alu_ofl,
  input  logic        ex_cout,
  input  logic [15:0] ex_store_data,
  input  logic [2:0]  ex_wr_reg,
  input  logic        ex_wr_en,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic        ex_halt,
  input  logic        stall,
  input  logic        flush,
  output logic        mem_valid,
  output logic [15:0] mem_instr,
  output logic [15:0] mem_alu_result,
  output logic        mem_alu_zero,
  output logic        mem_alu_ofl,
  output logic        mem_cout,
  output logic [15:0] mem_store_data,
  output logic [2:0]  mem_wr_reg,
  output logic        mem_wr_en,
  output logic        mem_mem_rd,
  output logic        mem_mem_wr,
  output logic        halted,
  output logic        ex_ready,
  output logic [15:0] insn_count
`ifdef EXMEM_FWD_EN
  ,
  output logic        fwd_en,
  output logic [2:0]  fwd_reg,
  output logic [15:0] fwd_data
`endif
);

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  logic        r_valid;
  logic [15:0] r_instr;
  logic [15:0] r_alu_result;
  logic        r_alu_zero;
  logic        r_alu_ofl;
  logic        r_cout;
  logic [15:0] r_store_data;
  logic [2:0]  r_wr_reg;
  logic        r_wr_en;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic        r_halted;
  logic [15:0] r_count;

  logic        w_valid;
  logic [15:0] w_instr;
  logic [15:0] w_alu_result;
  logic        w_alu_zero;
  logic        w_alu_ofl;
  logic        w_cout;
  logic [15:0] w_store_data;
  logic [2:0]  w_wr_reg;
  logic        w_wr_en;
  logic        w_mem_rd;
  logic        w_mem_wr;
  logic        w_halted;
  logic [15:0] w_count;
  logic        w_take;

  assign w_take = ex_valid & ~r_halted;

  // Next-state selection: flush beats stall beats load; an untaken load is a bubble.
  always_comb begin
    w_valid      = r_valid;
    w_instr      = r_instr;
    w_alu_result = r_alu_result;
    w_alu_zero   = r_alu_zero;
    w_alu_ofl    = r_alu_ofl;
    w_cout       = r_cout;
    w_store_data = r_store_data;
    w_wr_reg     = r_wr_reg;
    w_wr_en      = r_wr_en;
    w_mem_rd     = r_mem_rd;
    w_mem_wr     = r_mem_wr;
    w_halted     = r_halted;
    w_count      = r_count;
    if (!flush && stall) begin
      w_valid = r_valid;
    end else if (!flush && w_take) begin
      w_valid      = 1'b1;
      w_instr      = ex_instr;
      w_alu_result = ex_alu_result;
      w_alu_zero   = ex_alu_zero;
      w_alu_ofl    = ex_alu_ofl;
      w_cout       = ex_cout;
      w_store_data = ex_store_data;
      w_wr_reg     = ex_wr_reg;
      w_wr_en      = ex_wr_en & ~ex_halt;
      w_mem_rd     = ex_mem_rd & ~ex_halt;
      w_mem_wr     = ex_mem_wr & ~ex_halt;
      w_halted     = r_halted | ex_halt;
      w_count      = r_count + 16'd1;
    end else begin
      w_valid      = 1'b0;
      w_instr      = NOP_INSTR;
      w_alu_result = 16'h0000;
      w_alu_zero   = 1'b0;
      w_alu_ofl    = 1'b0;
      w_cout       = 1'b0;
      w_store_data = 16'h0000;
      w_wr_reg     = 3'd0;
      w_wr_en      = 1'b0;
      w_mem_rd     = 1'b0;
      w_mem_wr     = 1'b0;
    end
  end

  // Pipeline state, counter and sticky halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_alu_result <= 16'h0000;
      r_alu_zero   <= 1'b0;
      r_alu_ofl    <= 1'b0;
      r_cout       <= 1'b0;
      r_store_data <= 16'h0000;
      r_wr_reg     <= 3'd0;
      r_wr_en      <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_halted     <= 1'b0;
      r_count      <= 16'h0000;
    end else begin
      r_valid      <= w_valid;
      r_instr      <= w_instr;
      r_alu_result <= w_alu_result;
      r_alu_zero   <= w_alu_zero;
      r_alu_ofl    <= w_alu_ofl;
      r_cout       <= w_cout;
      r_store_data <= w_store_data;
      r_wr_reg     <= w_wr_reg;
      r_wr_en      <= w_wr_en;
      r_mem_rd     <= w_mem_rd;
      r_mem_wr     <= w_mem_wr;
      r_halted     <= w_halted;
      r_count      <= w_count;
    end
  end

  assign mem_valid      = r_valid;
  assign mem_instr      = r_instr;
  assign mem_alu_result = r_alu_result;
  assign mem_alu_zero   = r_alu_zero;
  assign mem_alu_ofl    = r_alu_ofl;
  assign mem_cout       = r_cout;
  assign mem_store_data = r_store_data;
  assign mem_wr_reg     = r_wr_reg;
  assign mem_wr_en      = r_wr_en;
  assign mem_mem_rd     = r_mem_rd;
  assign mem_mem_wr     = r_mem_wr;
  assign halted         = r_halted;
  assign insn_count     = r_count;
  // Upstream may only advance when MEM is free and no HALT has retired.
  assign ex_ready       = ~stall & ~r_halted;

`ifdef EXMEM_FWD_EN
  assign fwd_en   = r_valid & r_wr_en & ~r_mem_rd;
  assign fwd_reg  = r_wr_reg;
  assign fwd_data = r_alu_result;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized bench for ex_mem_reg against a transaction-level model, plus directed literal checks.
module tb_ex_mem_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_alu_zero = 1'b0, ex_alu_ofl = 1'b0, ex_cout = 1'b0;
  logic [15:0] ex_instr = 16'h0, ex_alu_result = 16'h0, ex_store_data = 16'h0;
  logic [2:0]  ex_wr_reg = 3'd0;
  logic        ex_wr_en = 1'b0, ex_mem_rd = 1'b0, ex_mem_wr = 1'b0, ex_halt = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        mem_valid, mem_alu_zero, mem_alu_ofl, mem_cout, mem_wr_en, mem_mem_rd, mem_mem_wr;
  logic [15:0] mem_instr, mem_alu_result, mem_store_data, insn_count;
  logic [2:0]  mem_wr_reg;
  logic        halted, ex_ready;
`ifdef EXMEM_FWD_EN
  logic        fwd_en;
  logic [2:0]  fwd_reg;
  logic [15:0] fwd_data;
`endif

  int n_checks = 0;
  int n_pass = 0;

  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_alu_result(ex_alu_result), .ex_alu_zero(ex_alu_zero), .ex_alu_ofl(ex_alu_ofl),
    .ex_cout(ex_cout), .ex_store_data(ex_store_data), .ex_wr_reg(ex_wr_reg),
    .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_halt(ex_halt),
    .stall(stall), .flush(flush), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_alu_result(mem_alu_result), .mem_alu_zero(mem_alu_zero), .mem_alu_ofl(mem_alu_ofl),
    .mem_cout(mem_cout), .mem_store_data(mem_store_data), .mem_wr_reg(mem_wr_reg),
    .mem_wr_en(mem_wr_en), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr),
    .halted(halted), .ex_ready(ex_ready), .insn_count(insn_count)
`ifdef EXMEM_FWD_EN
    , .fwd_en(fwd_en), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: the MEM-side view of the pipeline as plain variables.
  logic        m_valid, m_zero, m_ofl, m_cout, m_wr_en, m_rd, m_wr, m_halted;
  logic [15:0] m_instr, m_res, m_sd, m_count;
  logic [2:0]  m_wr_reg;

  task automatic model_bubble();
    m_valid = 1'b0; m_instr = 16'h0800; m_res = 16'h0; m_zero = 1'b0; m_ofl = 1'b0;
    m_cout = 1'b0; m_sd = 16'h0; m_wr_reg = 3'd0; m_wr_en = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_bubble();
      m_halted = 1'b0;
      m_count = 16'h0;
    end else if (flush) begin
      model_bubble();
    end else if (stall) begin
      m_count = m_count;
    end else if (ex_valid && !m_halted) begin
      m_valid = 1'b1; m_instr = ex_instr; m_res = ex_alu_result; m_zero = ex_alu_zero;
      m_ofl = ex_alu_ofl; m_cout = ex_cout; m_sd = ex_store_data; m_wr_reg = ex_wr_reg;
      m_wr_en = ex_halt ? 1'b0 : ex_wr_en;
      m_rd = ex_halt ? 1'b0 : ex_mem_rd;
      m_wr = ex_halt ? 1'b0 : ex_mem_wr;
      if (ex_halt) m_halted = 1'b1;
      m_count = m_count + 16'd1;
    end else begin
      model_bubble();
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("mem_valid", {15'd0, mem_valid}, {15'd0, m_valid});
    chk("mem_instr", mem_instr, m_instr);
    chk("mem_alu_result", mem_alu_result, m_res);
    chk("flags", {13'd0, mem_alu_zero, mem_alu_ofl, mem_cout}, {13'd0, m_zero, m_ofl, m_cout});
    chk("mem_store_data", mem_store_data, m_sd);
    chk("mem_wr_reg", {13'd0, mem_wr_reg}, {13'd0, m_wr_reg});
    chk("ctrl", {13'd0, mem_wr_en, mem_mem_rd, mem_mem_wr}, {13'd0, m_wr_en, m_rd, m_wr});
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
    chk("insn_count", insn_count, m_count);
    chk("ex_ready", {15'd0, ex_ready}, {15'd0, ~stall & ~m_halted});
`ifdef EXMEM_FWD_EN
    chk("fwd_en", {15'd0, fwd_en}, {15'd0, m_valid & m_wr_en & ~m_rd});
    chk("fwd_reg", {13'd0, fwd_reg}, {13'd0, m_wr_reg});
    chk("fwd_data", fwd_data, m_res);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] res, input logic [2:0] rg,
                       input logic we, input logic rd, input logic wr, input logic h,
                       input logic st, input logic fl);
    ex_valid = v; ex_instr = 16'h1000 | {13'd0, rg}; ex_alu_result = res;
    ex_alu_zero = (res == 16'h0); ex_alu_ofl = 1'b0; ex_cout = 1'b0; ex_store_data = ~res;
    ex_wr_reg = rg; ex_wr_en = we; ex_mem_rd = rd; ex_mem_wr = wr; ex_halt = h;
    stall = st; flush = fl;
  endtask

  task automatic drive_random(input logic allow_halt);
    ex_valid = ($urandom_range(3) != 0);
    ex_instr = 16'($urandom); ex_alu_result = 16'($urandom); ex_store_data = 16'($urandom);
    ex_alu_zero = 1'($urandom); ex_alu_ofl = 1'($urandom); ex_cout = 1'($urandom);
    ex_wr_reg = 3'($urandom); ex_wr_en = 1'($urandom); ex_mem_rd = 1'($urandom);
    ex_mem_wr = 1'($urandom);
    ex_halt = allow_halt && ($urandom_range(40) == 0);
    stall = ($urandom_range(3) == 0); flush = ($urandom_range(7) == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [15:0] held_res;
  logic [15:0] held_cnt;

  initial begin
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step();
    chk("rst_instr", mem_instr, 16'h0800);
    chk("rst_count", insn_count, 16'h0000);

    // Directed ADD load
    drive(1'b1, 16'h1234, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("add_result", mem_alu_result, 16'h1234);
    chk("add_wr_reg", {13'd0, mem_wr_reg}, 16'd3);
    chk("add_valid", {15'd0, mem_valid}, 16'd1);
    chk("add_count", insn_count, 16'd1);

    // Stall three cycles while EX changes, then take the latest value
    drive(1'b1, 16'hAAAA, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ex_alu_result = 16'hA000 + 16'(i);
      step();
      chk("stall_result", mem_alu_result, 16'h1234);
      chk("stall_count", insn_count, 16'd1);
    end
    ex_alu_result = 16'h5A5A; stall = 1'b0;
    step();
    chk("post_stall_result", mem_alu_result, 16'h5A5A);
    chk("post_stall_count", insn_count, 16'd2);

    // Flush with stall on a valid input
    drive(1'b1, 16'h7777, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("flush_valid", {15'd0, mem_valid}, 16'd0);
    chk("flush_instr", mem_instr, 16'h0800);
    chk("flush_count", insn_count, 16'd2);

`ifdef EXMEM_FWD_EN
    drive(1'b1, 16'hBEEF, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("fwd_en_lit", {15'd0, fwd_en}, 16'd1);
    chk("fwd_reg_lit", {13'd0, fwd_reg}, 16'd5);
    chk("fwd_data_lit", fwd_data, 16'hBEEF);
    ex_mem_rd = 1'b1;
    step();
    chk("fwd_en_load", {15'd0, fwd_en}, 16'd0);
`endif

    // Random traffic without HALT, then with rare HALT
    for (int i = 0; i < 400; i++) begin
      drive_random(1'b0);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      drive_random(1'b1);
      step();
      if (i % 100 == 99) do_reset();
    end

    // HALT retirement
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive(1'b1, 16'h4321, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("halt_set", {15'd0, halted}, 16'd1);
    chk("halt_wr_en", {15'd0, mem_wr_en}, 16'd0);
    chk("halt_ready", {15'd0, ex_ready}, 16'd0);
    drive(1'b1, 16'h1111, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("halt_bubble", {15'd0, mem_valid}, 16'd0);
    chk("halt_bubble_cnt", insn_count, 16'd1);
    flush = 1'b1;
    step();
    chk("halt_flush_sticky", {15'd0, halted}, 16'd1);
    do_reset();
    drive(1'b1, 16'h4321, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk("halt_flush_edge", {15'd0, halted}, 16'd0);

    // Counter wrap
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive(1'b1, 16'h0042, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (65535) step();
    chk("count_max", insn_count, 16'hFFFF);
    step();
    chk("count_wrap", insn_count, 16'h0000);

    // Asynchronous reset mid-cycle
    held_res = mem_alu_result;
    held_cnt = insn_count;
    chk("pre_reset_valid", {15'd0, mem_valid}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", {15'd0, mem_valid}, 16'd0);
    chk("async_instr", mem_instr, 16'h0800);
    chk("async_result", mem_alu_result, 16'h0000);
    chk("async_wr_en", {15'd0, mem_wr_en}, 16'd0);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Pipeline register between the execute stage and the memory stage. Captures the ALU result, flags, store data and memory/writeback control each cycle, and supports stall, flush and a sticky halt. Keeps a retired-into-MEM instruction counter. Its outputs feed the data-cache/memory stage and, optionally, the EX-stage forwarding muxes.

## Interface
- No parameters.
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a real instruction
- ex_instr  in  16  instruction in EX
- ex_alu_result  in  16  ALU output
- ex_alu_zero, ex_alu_ofl, ex_cout  in  1 each  ALU flags
- ex_store_data  in  16  second register operand (store data)
- ex_wr_reg  in  3  destination register
- ex_wr_en  in  1  register writeback enable
- ex_mem_rd, ex_mem_wr  in  1 each  load / store
- ex_halt  in  1  instruction is HALT
- stall  in  1  memory stage busy; hold register
- flush  in  1  squash; insert bubble
- mem_valid  out  1; mem_instr  out  16; mem_alu_result  out  16; mem_alu_zero, mem_alu_ofl, mem_cout  out  1 each; mem_store_data  out  16; mem_wr_reg  out  3; mem_wr_en, mem_mem_rd, mem_mem_wr  out  1 each  registered copies
- halted  out  1  sticky: HALT has entered MEM
- ex_ready  out  1  combinational, = !stall & !halted; upstream advances only when high
- insn_count  out  16  count of valid instructions loaded
- fwd_en  out  1; fwd_reg  out  3; fwd_data  out  16  only with EXMEM_FWD_EN

## Operation
- Per edge, priority: flush > stall > load.
- Flush: mem_valid=0, mem_wr_en=mem_mem_rd=mem_mem_wr=0, mem_instr=16'h0800 (NOP), data fields 0. halted and insn_count unchanged.
- Stall (no flush): every register holds, including insn_count.
- Load with ex_valid=1 and halted=0: capture all ex_* fields, mem_valid=1, insn_count+1 (mod 2^16, wraps 16'hFFFF→0). If ex_halt=1: mem_wr_en, mem_mem_rd, mem_mem_wr forced 0; halted set on the same edge.
- Load with ex_valid=0 or halted=1: bubble, identical to flush.
- ex_mem_rd and ex_mem_wr both 1: not legal; register captures as given, no checking.
- halted clears only on reset; flush does not clear it. Flush on the same edge as a HALT load wins: halted stays 0.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

## Timing
- Latency 1 cycle from ex_* to mem_*.
- Reset values: mem_valid 0, mem_instr 16'h0800, all other mem_* 0, halted 0, insn_count 0, fwd_en 0, fwd_reg 0, fwd_data 0.
- ex_ready is combinational from stall and halted; no register in that path.
- Stall of N cycles holds outputs constant for N cycles. The instruction presented during the stall is taken on the first non-stall edge.

## Configuration
- EXMEM_FWD_EN defined: fwd_en = mem_valid & mem_wr_en & !mem_mem_rd, fwd_reg = mem_wr_reg, fwd_data = mem_alu_result, all combinational from the register outputs.
- EXMEM_FWD_EN undefined: fwd_* ports are absent. All other behaviour is identical.

## Test plan
- Reset then load ADD: ex_valid=1, result 16'h1234, wr_reg 3, wr_en 1 -> next cycle mem_alu_result=16'h1234, mem_wr_reg=3, mem_valid=1, insn_count=1.
- Stall 3 cycles while ex_* changes -> mem_* and insn_count constant; first non-stall edge loads the current ex_* value.
- Flush and stall asserted together on a valid input -> mem_valid=0, mem_instr=16'h0800, insn_count unchanged.
- HALT load -> halted=1, mem_wr_en=0, ex_ready=0. A subsequent valid ADD -> bubble; flush leaves halted=1. Flush on the HALT edge itself -> halted=0.
- Preload insn_count at 16'hFFFF (65535 loads), load one more -> 16'h0000. Drop rst_n mid-cycle -> outputs at reset values before the next edge.
- With EXMEM_FWD_EN: load wr_en=1, wr_reg 5, result 16'hBEEF -> fwd_en=1, fwd_reg=5, fwd_data=16'hBEEF. Same input with mem_rd=1 -> fwd_en=0.
